// File: rtl/riscv_pkg.sv
// Shared RV32i definitions: opcodes, ALU operation codes, writeback source
// encoding and immediate formats used by the decode stage.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_SLL    = 4'b0010,
    ALU_SLT    = 4'b0011,
    ALU_SLTU   = 4'b0100,
    ALU_XOR    = 4'b0101,
    ALU_SRL    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_OR     = 4'b1000,
    ALU_AND    = 4'b1001,
    ALU_PASS_B = 4'b1010
  } alu_op_e;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // alt selects the SUB/SRA variant of funct3 000/101
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// 32x32 architectural register file: x0 hardwired to zero, one write port
// from writeback, two asynchronous read ports with write-through bypass.
module register_file (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);

  logic [31:0] r_regs [1:31];
  logic        w_wr_valid;

  assign w_wr_valid = i_we && (i_wa != 5'd0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 1; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wr_valid) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // Bypass lets a WB->ID read in the same cycle see the value being written
  always_comb begin
    if (i_ra1 == 5'd0)                      o_rd1 = '0;
    else if (w_wr_valid && i_wa == i_ra1)   o_rd1 = i_wd;
    else                                    o_rd1 = r_regs[i_ra1];
  end

  always_comb begin
    if (i_ra2 == 5'd0)                      o_rd2 = '0;
    else if (w_wr_valid && i_wa == i_ra2)   o_rd2 = i_wd;
    else                                    o_rd2 = r_regs[i_ra2];
  end

endmodule

// File: rtl/decode_stage.sv
// RV32i instruction decode stage: control bundle, register indices, operand
// read data and sign-extended immediate for the ID/EX register.
module decode_stage
  import riscv_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Instr_D,
  input  logic        REG_W_En_W,
  input  logic [4:0]  RD_W,
  input  logic [31:0] Result_W,
  output logic        REG_W_En_D,
  output logic        MEM_W_En_D,
  output logic        Jump_En_D,
  output logic        Branch_En_D,
  output logic [2:0]  MEM_Control_D,
  output logic [3:0]  ALU_Control_D,
  output logic        Branch_Src_Sel_D,
  output logic        ALU_SrcA_Sel_D,
  output logic        ALU_SrcB_Sel_D,
  output logic [1:0]  Result_Src_Sel_D,
  output logic [4:0]  RD_D,
  output logic [4:0]  RS1_D,
  output logic [4:0]  RS2_D,
  output logic [31:0] REG_R_Data1_D,
  output logic [31:0] REG_R_Data2_D,
  output logic [31:0] Imm_Ext_D,
  output logic        Illegal_Instr_D
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_reg_w, w_mem_w, w_jump, w_branch;
  logic [2:0] w_mem_ctl;
  alu_op_e    w_alu;
  logic       w_bsrc, w_srca, w_srcb, w_illegal;
  logic [1:0] w_res;
  imm_fmt_e   w_fmt;

  assign w_opcode = Instr_D[6:0];
  assign w_funct3 = Instr_D[14:12];
  assign w_funct7 = Instr_D[31:25];
  assign RD_D     = Instr_D[11:7];
  assign RS1_D    = Instr_D[19:15];
  assign RS2_D    = Instr_D[24:20];

  register_file u_rf (
    .CLK   (CLK),
    .RST   (RST),
    .i_we  (REG_W_En_W),
    .i_wa  (RD_W),
    .i_wd  (Result_W),
    .i_ra1 (RS1_D),
    .i_ra2 (RS2_D),
    .o_rd1 (REG_R_Data1_D),
    .o_rd2 (REG_R_Data2_D)
  );

  always_comb begin
    w_reg_w   = 1'b0;
    w_mem_w   = 1'b0;
    w_jump    = 1'b0;
    w_branch  = 1'b0;
    w_mem_ctl = 3'b000;
    w_alu     = ALU_ADD;
    w_bsrc    = 1'b0;
    w_srca    = 1'b0;
    w_srcb    = 1'b0;
    w_res     = RES_ALU;
    w_fmt     = IMM_NONE;
    w_illegal = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_illegal = !((w_funct7 == 7'h00) ||
                      (w_funct7 == 7'h20 && (w_funct3 == 3'b000 || w_funct3 == 3'b101)));
        w_alu     = alu_from_funct3(w_funct3, w_funct7[5]);
        w_reg_w   = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only the shift-immediates constrain funct7; elsewhere it is immediate bits
        if (w_funct3 == 3'b001)      w_illegal = (w_funct7 != 7'h00);
        else if (w_funct3 == 3'b101) w_illegal = (w_funct7 != 7'h00) && (w_funct7 != 7'h20);
        w_alu   = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
        w_srcb  = 1'b1;
        w_reg_w = 1'b1;
        w_fmt   = IMM_I;
      end
      OPC_LOAD: begin
        w_illegal = (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11);
        w_srcb    = 1'b1;
        w_reg_w   = 1'b1;
        w_res     = RES_MEM;
        w_mem_ctl = w_funct3;
        w_fmt     = IMM_I;
      end
      OPC_STORE: begin
        w_illegal = w_funct3[2] || (w_funct3[1:0] == 2'b11);
        w_srcb    = 1'b1;
        w_mem_w   = 1'b1;
        w_mem_ctl = w_funct3;
        w_fmt     = IMM_S;
      end
      OPC_BRANCH: begin
        w_illegal = (w_funct3[2:1] == 2'b01);
        w_alu     = w_funct3[2] ? (w_funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        w_branch  = 1'b1;
        w_mem_ctl = w_funct3;
        w_fmt     = IMM_B;
      end
      OPC_JAL: begin
        w_jump  = 1'b1;
        w_reg_w = 1'b1;
        w_res   = RES_PC4;
        w_fmt   = IMM_J;
      end
      OPC_JALR: begin
        w_illegal = (w_funct3 != 3'b000);
        w_jump    = 1'b1;
        w_bsrc    = 1'b1;
        w_reg_w   = 1'b1;
        w_res     = RES_PC4;
        w_fmt     = IMM_I;
      end
      OPC_LUI: begin
        w_alu   = ALU_PASS_B;
        w_srcb  = 1'b1;
        w_reg_w = 1'b1;
        w_fmt   = IMM_U;
      end
      OPC_AUIPC: begin
        w_srca  = 1'b1;
        w_srcb  = 1'b1;
        w_reg_w = 1'b1;
        w_fmt   = IMM_U;
      end
      OPC_FENCE, OPC_SYSTEM: ;
      // The all-zero word is the post-reset bubble and decodes as a NOP
      default: w_illegal = (Instr_D != 32'h0);
    endcase
  end

  always_comb begin
    case (w_fmt)
      IMM_I:   Imm_Ext_D = {{20{Instr_D[31]}}, Instr_D[31:20]};
      IMM_S:   Imm_Ext_D = {{20{Instr_D[31]}}, Instr_D[31:25], Instr_D[11:7]};
      IMM_B:   Imm_Ext_D = {{19{Instr_D[31]}}, Instr_D[31], Instr_D[7], Instr_D[30:25],
                            Instr_D[11:8], 1'b0};
      IMM_U:   Imm_Ext_D = {Instr_D[31:12], 12'h000};
      IMM_J:   Imm_Ext_D = {{11{Instr_D[31]}}, Instr_D[31], Instr_D[19:12], Instr_D[20],
                            Instr_D[30:21], 1'b0};
      default: Imm_Ext_D = 32'h0;
    endcase
  end

  assign REG_W_En_D       = w_reg_w  & ~w_illegal;
  assign MEM_W_En_D       = w_mem_w  & ~w_illegal;
  assign Jump_En_D        = w_jump   & ~w_illegal;
  assign Branch_En_D      = w_branch & ~w_illegal;
  assign MEM_Control_D    = w_mem_ctl;
  assign ALU_Control_D    = w_alu;
  assign Branch_Src_Sel_D = w_bsrc;
  assign ALU_SrcA_Sel_D   = w_srca;
  assign ALU_SrcB_Sel_D   = w_srcb;
  assign Result_Src_Sel_D = w_res;
  assign Illegal_Instr_D  = w_illegal;

endmodule
